// File: rtl/spi_shared_arb.sv
// spi_shared_arb: round-robin sharing of one 16-bit SPI master between the inertial and A2D requesters,
// with slave-select routing, read-data return and a watchdog that aborts a hung transaction.
module spi_shared_arb #(
  parameter int CMD_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt_inert,
  input  logic [CMD_W-1:0] cmd_inert,
  output logic             done_inert,
  output logic [CMD_W-1:0] rd_inert,
  input  logic             wrt_a2d,
  input  logic [CMD_W-1:0] cmd_a2d,
  output logic             done_a2d,
  output logic [CMD_W-1:0] rd_a2d,
  output logic             wrt_spi,
  output logic [CMD_W-1:0] cmd_spi,
  input  logic             done_spi,
  input  logic [CMD_W-1:0] rd_spi,
  input  logic             SS_n_spi,
  output logic             SS_inert_n,
  output logic             SS_a2d_n,
  output logic             err
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam logic INERT = 1'b0;
  localparam logic A2D   = 1'b1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d, last_gnt_q, last_gnt_d;
  logic             pend_inert_q, pend_inert_d, pend_a2d_q, pend_a2d_d;
  logic [CMD_W-1:0] cmd_inert_q, cmd_inert_d, cmd_a2d_q, cmd_a2d_d;
  logic [CMD_W-1:0] cmd_spi_q, cmd_spi_d;
  logic [CMD_W-1:0] rd_inert_q, rd_inert_d, rd_a2d_q, rd_a2d_d;
  logic             wrt_spi_q, wrt_spi_d, err_q, err_d;
  logic             done_inert_q, done_inert_d, done_a2d_q, done_a2d_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             nxt, fin, busy;

  // Tie goes to whoever was not served last; otherwise the lone pending requester.
  assign nxt  = (pend_inert_q && pend_a2d_q) ? ~last_gnt_q : pend_a2d_q;
  assign fin  = (state_q == WAIT) && (done_spi || wd_q == WD_MAX);
  assign busy = state_q != IDLE;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_gnt_d   = last_gnt_q;
    cmd_spi_d    = cmd_spi_q;
    wrt_spi_d    = 1'b0;
    wd_d         = (state_q == WAIT) ? wd_q + 1'b1 : '0;
    pend_inert_d = (pend_inert_q || wrt_inert) && !(fin && gnt_q == INERT);
    pend_a2d_d   = (pend_a2d_q || wrt_a2d) && !(fin && gnt_q == A2D);
    cmd_inert_d  = (wrt_inert && !pend_inert_q) ? cmd_inert : cmd_inert_q;
    cmd_a2d_d    = (wrt_a2d && !pend_a2d_q) ? cmd_a2d : cmd_a2d_q;
    done_inert_d = fin && gnt_q == INERT;
    done_a2d_d   = fin && gnt_q == A2D;
    err_d        = fin && !done_spi;
    rd_inert_d   = (done_inert_d && done_spi) ? rd_spi : rd_inert_q;
    rd_a2d_d     = (done_a2d_d && done_spi) ? rd_spi : rd_a2d_q;
    case (state_q)
      IDLE: if (pend_inert_q || pend_a2d_q) begin
        state_d    = LAUNCH;
        gnt_d      = nxt;
        last_gnt_d = nxt;
        cmd_spi_d  = nxt ? cmd_a2d_q : cmd_inert_q;
        wrt_spi_d  = 1'b1;
      end
      LAUNCH:  state_d = WAIT;
      WAIT:    state_d = fin ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= INERT;
      last_gnt_q   <= A2D;
      pend_inert_q <= 1'b0;
      pend_a2d_q   <= 1'b0;
      cmd_inert_q  <= '0;
      cmd_a2d_q    <= '0;
      cmd_spi_q    <= '0;
      rd_inert_q   <= '0;
      rd_a2d_q     <= '0;
      wrt_spi_q    <= 1'b0;
      done_inert_q <= 1'b0;
      done_a2d_q   <= 1'b0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_gnt_q   <= last_gnt_d;
      pend_inert_q <= pend_inert_d;
      pend_a2d_q   <= pend_a2d_d;
      cmd_inert_q  <= cmd_inert_d;
      cmd_a2d_q    <= cmd_a2d_d;
      cmd_spi_q    <= cmd_spi_d;
      rd_inert_q   <= rd_inert_d;
      rd_a2d_q     <= rd_a2d_d;
      wrt_spi_q    <= wrt_spi_d;
      done_inert_q <= done_inert_d;
      done_a2d_q   <= done_a2d_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
    end
  end

  // Only the granted device ever sees the master's select, so both can never be low together.
  assign SS_inert_n = ~(busy && gnt_q == INERT) | SS_n_spi;
  assign SS_a2d_n   = ~(busy && gnt_q == A2D) | SS_n_spi;
  assign wrt_spi    = wrt_spi_q;
  assign cmd_spi    = cmd_spi_q;
  assign done_inert = done_inert_q;
  assign done_a2d   = done_a2d_q;
  assign rd_inert   = rd_inert_q;
  assign rd_a2d     = rd_a2d_q;
  assign err        = err_q;
endmodule

// File: tb/tb_spi_shared_arb.sv
// tb_spi_shared_arb: directed scenarios plus a randomized run against a request/grant scoreboard.
module tb_spi_shared_arb;
  localparam int W  = 16;
  localparam int TO = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wrt_inert = 1'b0, wrt_a2d = 1'b0, done_spi = 1'b0, SS_n_spi = 1'b1;
  logic [W-1:0] cmd_inert = '0, cmd_a2d = '0, rd_spi = '0;
  logic done_inert, done_a2d, wrt_spi, SS_inert_n, SS_a2d_n, err;
  logic [W-1:0] rd_inert, rd_a2d, cmd_spi;
  int vecs = 0, errs = 0, cyc = 0, launches = 0;

  always #5 clk = ~clk;

  spi_shared_arb #(.CMD_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wrt_inert(wrt_inert), .cmd_inert(cmd_inert), .done_inert(done_inert), .rd_inert(rd_inert),
    .wrt_a2d(wrt_a2d), .cmd_a2d(cmd_a2d), .done_a2d(done_a2d), .rd_a2d(rd_a2d),
    .wrt_spi(wrt_spi), .cmd_spi(cmd_spi), .done_spi(done_spi), .rd_spi(rd_spi),
    .SS_n_spi(SS_n_spi), .SS_inert_n(SS_inert_n), .SS_a2d_n(SS_a2d_n), .err(err)
  );

  always @(negedge clk) if (wrt_spi) launches++;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_launch(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (wrt_spi) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic serve(input logic [W-1:0] rd, input int hold);
    SS_n_spi = 1'b0;
    repeat (hold) tick();
    rd_spi = rd;
    done_spi = 1'b1;
    SS_n_spi = 1'b1;
    tick();
    done_spi = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wrt_inert = 1'b0; wrt_a2d = 1'b0; done_spi = 1'b0; SS_n_spi = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n_spi = 1'b0; wrt_inert = 1'b1; wrt_a2d = 1'b1; done_spi = 1'b1;
    cmd_inert = 16'hFFFF; cmd_a2d = 16'hFFFF; rd_spi = 16'hFFFF;
    repeat (2) tick();
    vecs++; if ({wrt_spi, done_inert, done_a2d, err} !== 4'b0000) begin errs++;
      $display("FAIL reset_pulses: got %b want 0000", {wrt_spi, done_inert, done_a2d, err}); end
    vecs++; if (rd_inert !== 16'h0 || rd_a2d !== 16'h0) begin errs++;
      $display("FAIL reset_rd: got %h/%h want 0000/0000", rd_inert, rd_a2d); end
    vecs++; if (cmd_spi !== 16'h0) begin errs++;
      $display("FAIL reset_cmd_spi: got %h want 0000", cmd_spi); end
    vecs++; if (SS_inert_n !== 1'b1 || SS_a2d_n !== 1'b1) begin errs++;
      $display("FAIL reset_ss: got %b%b want 11", SS_inert_n, SS_a2d_n); end
    wrt_inert = 1'b0; wrt_a2d = 1'b0; done_spi = 1'b0; SS_n_spi = 1'b1; rst_n = 1'b1;
    repeat (4) tick();
    vecs++; if (launches !== 0) begin errs++;
      $display("FAIL reset_no_launch: got %0d launches want 0", launches); end
  endtask

  task automatic test_single();
    int n;
    cmd_inert = 16'hA500; wrt_inert = 1'b1;
    tick();
    wrt_inert = 1'b0; cmd_inert = 16'h0BAD;
    wait_launch(n);
    vecs++; if (n !== 1) begin errs++; $display("FAIL single_latency: got %0d want 1", n); end
    vecs++; if (cmd_spi !== 16'hA500) begin errs++; $display("FAIL single_cmd: got %h want a500", cmd_spi); end
    tick();
    vecs++; if (wrt_spi !== 1'b0) begin errs++; $display("FAIL single_wrt_width: got %b want 0", wrt_spi); end
    SS_n_spi = 1'b0; #1;
    vecs++; if (SS_inert_n !== 1'b0 || SS_a2d_n !== 1'b1) begin errs++;
      $display("FAIL single_ss_low: got %b%b want 01", SS_inert_n, SS_a2d_n); end
    repeat (40) tick();
    SS_n_spi = 1'b1; #1;
    vecs++; if (SS_inert_n !== 1'b1 || SS_a2d_n !== 1'b1) begin errs++;
      $display("FAIL single_ss_follow: got %b%b want 11", SS_inert_n, SS_a2d_n); end
    vecs++; if (cmd_spi !== 16'hA500) begin errs++; $display("FAIL single_cmd_stable: got %h want a500", cmd_spi); end
    rd_spi = 16'h1234; done_spi = 1'b1;
    tick();
    done_spi = 1'b0;
    vecs++; if ({done_inert, done_a2d, err} !== 3'b100) begin errs++;
      $display("FAIL single_done: got %b want 100", {done_inert, done_a2d, err}); end
    vecs++; if (rd_inert !== 16'h1234 || rd_a2d !== 16'h0) begin errs++;
      $display("FAIL single_rd: got %h/%h want 1234/0000", rd_inert, rd_a2d); end
    tick();
    SS_n_spi = 1'b0; #1;
    vecs++; if (done_inert !== 1'b0 || SS_inert_n !== 1'b1 || SS_a2d_n !== 1'b1) begin errs++;
      $display("FAIL single_after: got done=%b ss=%b%b want 0 11", done_inert, SS_inert_n, SS_a2d_n); end
    SS_n_spi = 1'b1;
  endtask

  task automatic test_tie();
    int n;
    do_reset();
    cmd_inert = 16'h8F00; cmd_a2d = 16'h4000; wrt_inert = 1'b1; wrt_a2d = 1'b1;
    tick();
    wrt_inert = 1'b0; wrt_a2d = 1'b0;
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h8F00) begin errs++;
      $display("FAIL tie1_first: got n=%0d cmd=%h want 1 8f00", n, cmd_spi); end
    serve(16'h1111, 3);
    vecs++; if (done_inert !== 1'b1 || done_a2d !== 1'b0 || rd_inert !== 16'h1111) begin errs++;
      $display("FAIL tie1_done_inert: got %b%b rd=%h want 10 1111", done_inert, done_a2d, rd_inert); end
    cmd_inert = 16'h8F01; cmd_a2d = 16'h4001; wrt_inert = 1'b1; wrt_a2d = 1'b1;
    tick();
    wrt_inert = 1'b0; wrt_a2d = 1'b0;
    vecs++; if (wrt_spi !== 1'b1 || cmd_spi !== 16'h4000) begin errs++;
      $display("FAIL tie1_second: got wrt=%b cmd=%h want 1 4000", wrt_spi, cmd_spi); end
    serve(16'h2222, 3);
    vecs++; if (done_a2d !== 1'b1 || done_inert !== 1'b0 || rd_a2d !== 16'h2222 || rd_inert !== 16'h1111) begin errs++;
      $display("FAIL tie1_done_a2d: got %b%b rd=%h/%h want 01 1111/2222", done_inert, done_a2d, rd_inert, rd_a2d); end
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h8F01) begin errs++;
      $display("FAIL tie_rewrt: got n=%0d cmd=%h want 1 8f01", n, cmd_spi); end
    serve(16'h3333, 2);
    vecs++; if (done_inert !== 1'b1 || rd_inert !== 16'h3333) begin errs++;
      $display("FAIL tie_rewrt_done: got %b rd=%h want 1 3333", done_inert, rd_inert); end
    repeat (2) tick();
    cmd_inert = 16'h8F02; cmd_a2d = 16'h4002; wrt_inert = 1'b1; wrt_a2d = 1'b1;
    tick();
    wrt_inert = 1'b0; wrt_a2d = 1'b0;
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h4002) begin errs++;
      $display("FAIL tie2_first: got n=%0d cmd=%h want 1 4002", n, cmd_spi); end
    serve(16'h4444, 4);
    vecs++; if (done_a2d !== 1'b1 || rd_a2d !== 16'h4444 || rd_inert !== 16'h3333) begin errs++;
      $display("FAIL tie2_done_a2d: got %b rd=%h/%h want 1 3333/4444", done_a2d, rd_inert, rd_a2d); end
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h8F02) begin errs++;
      $display("FAIL tie2_second: got n=%0d cmd=%h want 1 8f02", n, cmd_spi); end
    serve(16'h5151, 2);
    vecs++; if (done_inert !== 1'b1 || rd_inert !== 16'h5151 || rd_a2d !== 16'h4444) begin errs++;
      $display("FAIL tie2_done_inert: got %b rd=%h/%h want 1 5151/4444", done_inert, rd_inert, rd_a2d); end
  endtask

  task automatic test_overlap();
    int n, l0;
    repeat (2) tick();
    l0 = launches;
    cmd_inert = 16'h1111; wrt_inert = 1'b1;
    tick();
    wrt_inert = 1'b0;
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h1111) begin errs++;
      $display("FAIL ovl_launch: got n=%0d cmd=%h want 1 1111", n, cmd_spi); end
    SS_n_spi = 1'b0;
    tick();
    cmd_a2d = 16'h2222; wrt_a2d = 1'b1;
    tick();
    wrt_a2d = 1'b0; cmd_a2d = 16'hEEEE;
    tick();
    cmd_inert = 16'h9999; wrt_inert = 1'b1;
    tick();
    wrt_inert = 1'b0;
    tick();
    vecs++; if (cmd_spi !== 16'h1111 || SS_inert_n !== 1'b0 || SS_a2d_n !== 1'b1) begin errs++;
      $display("FAIL ovl_stable: got cmd=%h ss=%b%b want 1111 01", cmd_spi, SS_inert_n, SS_a2d_n); end
    serve(16'h5555, 3);
    vecs++; if (done_inert !== 1'b1 || rd_inert !== 16'h5555 || rd_a2d !== 16'h4444) begin errs++;
      $display("FAIL ovl_done_inert: got %b rd=%h/%h want 1 5555/4444", done_inert, rd_inert, rd_a2d); end
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h2222) begin errs++;
      $display("FAIL ovl_a2d_launch: got n=%0d cmd=%h want 1 2222", n, cmd_spi); end
    serve(16'h6666, 3);
    vecs++; if (done_a2d !== 1'b1 || rd_a2d !== 16'h6666) begin errs++;
      $display("FAIL ovl_done_a2d: got %b rd=%h want 1 6666", done_a2d, rd_a2d); end
    repeat (6) tick();
    vecs++; if (launches - l0 !== 2) begin errs++;
      $display("FAIL ovl_launch_count: got %0d want 2", launches - l0); end
  endtask

  task automatic test_timeout();
    int n;
    cmd_a2d = 16'h7777; wrt_a2d = 1'b1;
    tick();
    wrt_a2d = 1'b0;
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h7777) begin errs++;
      $display("FAIL to_launch: got n=%0d cmd=%h want 1 7777", n, cmd_spi); end
    SS_n_spi = 1'b0; rd_spi = 16'hDEAD;
    tick();
    n = -1;
    for (int i = 0; i < 200; i++) begin
      if (done_a2d) begin
        n = i;
        break;
      end
      tick();
    end
    vecs++; if (n !== TO) begin errs++; $display("FAIL to_cycles: got %0d want %0d", n, TO); end
    vecs++; if (err !== 1'b1 || done_inert !== 1'b0 || rd_a2d !== 16'h6666) begin errs++;
      $display("FAIL to_abort: got err=%b di=%b rd=%h want 1 0 6666", err, done_inert, rd_a2d); end
    SS_n_spi = 1'b1;
    tick();
    vecs++; if (err !== 1'b0 || done_a2d !== 1'b0) begin errs++;
      $display("FAIL to_pulse_width: got %b%b want 00", err, done_a2d); end
    cmd_inert = 16'h3C3C; wrt_inert = 1'b1;
    tick();
    wrt_inert = 1'b0;
    wait_launch(n);
    vecs++; if (n !== 1 || cmd_spi !== 16'h3C3C) begin errs++;
      $display("FAIL to_next_launch: got n=%0d cmd=%h want 1 3c3c", n, cmd_spi); end
    serve(16'h4242, 5);
    vecs++; if (done_inert !== 1'b1 || err !== 1'b0 || rd_inert !== 16'h4242) begin errs++;
      $display("FAIL to_next_done: got %b err=%b rd=%h want 1 0 4242", done_inert, err, rd_inert); end
  endtask

  task automatic test_reset_mid();
    int n, l0;
    repeat (2) tick();
    cmd_inert = 16'h0F0F; wrt_inert = 1'b1;
    tick();
    wrt_inert = 1'b0;
    wait_launch(n);
    SS_n_spi = 1'b0;
    tick();
    cmd_a2d = 16'h1234; wrt_a2d = 1'b1;
    tick();
    wrt_a2d = 1'b0;
    repeat (3) tick();
    vecs++; if (n !== 1 || SS_inert_n !== 1'b0) begin errs++;
      $display("FAIL rm_active: got n=%0d ss_inert=%b want 1 0", n, SS_inert_n); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (SS_inert_n !== 1'b1 || SS_a2d_n !== 1'b1) begin errs++;
      $display("FAIL rm_ss_async: got %b%b want 11", SS_inert_n, SS_a2d_n); end
    vecs++; if (wrt_spi !== 1'b0 || cmd_spi !== 16'h0 || rd_inert !== 16'h0 || rd_a2d !== 16'h0) begin errs++;
      $display("FAIL rm_outputs: got wrt=%b cmd=%h rd=%h/%h want 0 0000 0000/0000", wrt_spi, cmd_spi, rd_inert, rd_a2d); end
    #1 rst_n = 1'b1;
    l0 = launches;
    rd_spi = 16'hFFFF; done_spi = 1'b1;
    tick();
    done_spi = 1'b0; SS_n_spi = 1'b1;
    vecs++; if (done_inert !== 1'b0 || done_a2d !== 1'b0 || rd_inert !== 16'h0) begin errs++;
      $display("FAIL rm_late_done: got %b%b rd=%h want 00 0000", done_inert, done_a2d, rd_inert); end
    repeat (10) tick();
    vecs++; if (launches !== l0) begin errs++;
      $display("FAIL rm_pend_cleared: got %0d launches want 0", launches - l0); end
  endtask

  task automatic test_random();
    bit out_i = 0, out_a = 0, sent = 0, due = 0, prev_idle = 1, el_i, el_a;
    int acc_i = 0, acc_a = 0, act = -1, last = 1, cnt = 0, nacc = 0, ndone = 0, own;
    logic [W-1:0] mc_i = '0, mc_a = '0, mrd_i = '0, mrd_a = '0, erd = '0;
    do_reset();
    for (int it = 0; it < 10500; it++) begin
      tick();
      vecs++;
      if (due) begin
        if (done_inert !== (act == 0) || done_a2d !== (act == 1) || err !== 1'b0) begin errs++;
          $display("FAIL rnd_done: cyc %0d got %b%b err=%b owner=%0d", cyc, done_inert, done_a2d, err, act); end
        if (act == 0) begin mrd_i = erd; out_i = 0; end
        else begin mrd_a = erd; out_a = 0; end
        ndone++; act = -1; due = 0; sent = 0;
      end else if (done_inert || done_a2d || err) begin errs++;
        $display("FAIL rnd_spurious_done: cyc %0d got %b%b%b want 000", cyc, done_inert, done_a2d, err);
      end
      vecs++; if (rd_inert !== mrd_i || rd_a2d !== mrd_a) begin errs++;
        $display("FAIL rnd_rd: cyc %0d got %h/%h want %h/%h", cyc, rd_inert, rd_a2d, mrd_i, mrd_a); end
      el_i = out_i && acc_i < cyc;
      el_a = out_a && acc_a < cyc;
      own = (el_i && el_a) ? (last == 0 ? 1 : 0) : (el_a ? 1 : 0);
      if (wrt_spi) begin
        vecs++;
        if (act >= 0 || !(el_i || el_a) || cmd_spi !== (own == 1 ? mc_a : mc_i)) begin errs++;
          $display("FAIL rnd_launch: cyc %0d got cmd=%h want owner %0d cmd %h", cyc, cmd_spi, own, own == 1 ? mc_a : mc_i); end
        act = own; last = own; cnt = $urandom_range(1, 20);
      end else if (prev_idle && (el_i || el_a)) begin
        vecs++; errs++;
        $display("FAIL rnd_missed_grant: cyc %0d got no wrt_spi want launch for %0d", cyc, own);
      end
      vecs++;
      if ((!SS_inert_n && !SS_a2d_n) || SS_inert_n !== (act == 0 ? SS_n_spi : 1'b1) ||
          SS_a2d_n !== (act == 1 ? SS_n_spi : 1'b1)) begin errs++;
        $display("FAIL rnd_ss: cyc %0d got %b%b ss_spi=%b owner=%0d", cyc, SS_inert_n, SS_a2d_n, SS_n_spi, act);
      end
      prev_idle = act < 0;
      wrt_inert = 1'b0; wrt_a2d = 1'b0; done_spi = 1'b0;
      if (it < 10000) begin
        wrt_inert = $urandom_range(0, 5) == 0;
        wrt_a2d = $urandom_range(0, 5) == 0;
        cmd_inert = W'($urandom);
        cmd_a2d = W'($urandom);
        if (wrt_inert && !out_i) begin out_i = 1; mc_i = cmd_inert; acc_i = cyc + 1; nacc++; end
        if (wrt_a2d && !out_a) begin out_a = 1; mc_a = cmd_a2d; acc_a = cyc + 1; nacc++; end
      end
      if (act >= 0 && !sent) begin
        if (cnt == 0) begin
          rd_spi = W'($urandom); erd = rd_spi; done_spi = 1'b1; SS_n_spi = 1'b1; sent = 1; due = 1;
        end else begin
          cnt--;
          SS_n_spi = $urandom_range(0, 3) == 0;
        end
      end else if (act < 0) begin
        SS_n_spi = 1'($urandom);
        rd_spi = W'($urandom);
        done_spi = $urandom_range(0, 15) == 0;
      end
    end
    wrt_inert = 1'b0; wrt_a2d = 1'b0; done_spi = 1'b0; SS_n_spi = 1'b1;
    vecs++; if (out_i || out_a || act >= 0) begin errs++;
      $display("FAIL rnd_drain: got outstanding %b%b owner=%0d want none", out_i, out_a, act); end
    vecs++; if (nacc !== ndone) begin errs++;
      $display("FAIL rnd_count: got %0d dones want %0d", ndone, nacc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_overlap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
